// File: rtl/store_commit_drain.sv
// store_commit_drain: pops committed stores from the store buffer, one at a time, into the dcache write port.
// Optional feature macro DRAIN_KSEG_MAP_EN: strip kseg0/kseg1 region bits and mark kseg1 writes uncached.
module store_commit_drain #(
  parameter int SB_DEPTH     = 16,
  parameter int RETIRE_WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [$clog2(RETIRE_WIDTH+1)-1:0] retire_store_cnt,
  output logic                              commit_store_valid,
  input  logic [3:0]                        commit_store_wstrb,
  input  logic [2:0]                        commit_store_size,
  input  logic [31:0]                       commit_store_addr,
  input  logic [31:0]                       commit_store_data,
  output logic                              data_req,
  output logic                              data_wr,
  output logic [1:0]                        data_size,
  output logic [3:0]                        data_wstrb,
  output logic [31:0]                       data_addr,
  output logic [31:0]                       data_wdata,
  output logic                              data_uncached,
  input  logic                              data_addr_ok,
  input  logic                              data_data_ok,
  output logic [$clog2(SB_DEPTH):0]         pending_cnt,
  output logic                              store_drained,
  output logic                              overflow_err
);

  localparam int CNT_W = $clog2(SB_DEPTH) + 1;
  localparam int RC_W  = $clog2(RETIRE_WIDTH + 1);
  localparam int SUM_W = CNT_W + RC_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_pop;
  logic             w_req;

  logic [CNT_W-1:0] r_pending;
  logic             r_overflow;
  logic [SUM_W-1:0] w_sum;
  logic             w_sat;
  logic [CNT_W-1:0] w_pending_nxt;

  logic [3:0]       r_wstrb;
  logic [1:0]       r_size;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;

  function automatic logic [1:0] map_size(input logic [2:0] size);
    case (size)
      3'd1:    map_size = 2'd0;
      3'd2:    map_size = 2'd1;
      default: map_size = 2'd2;
    endcase
  endfunction

  function automatic logic [31:0] map_addr(input logic [31:0] addr);
`ifdef DRAIN_KSEG_MAP_EN
    // kseg0 (100) and kseg1 (101) share the 2'b10 prefix and both fold onto physical 0.
    if (addr[31:30] == 2'b10) map_addr = {3'b000, addr[28:0]};
    else                      map_addr = addr;
`else
    map_addr = addr;
`endif
  endfunction

  // Pop only from registered state, so a store retired this cycle drains next cycle at the earliest.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_req       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pop = (r_pending != '0);
        if (w_pop) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        w_req = 1'b1;
        if (data_addr_ok) w_state_nxt = data_data_ok ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (data_data_ok) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // pending never underflows: a pop only happens while it is non-zero.
  always_comb begin
    w_sum         = SUM_W'(r_pending) + SUM_W'(retire_store_cnt) - SUM_W'(w_pop);
    w_sat         = (w_sum > SUM_W'(SB_DEPTH));
    w_pending_nxt = w_sat ? CNT_W'(SB_DEPTH) : w_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_sat) r_overflow <= 1'b1;
    end
  end

  // Holding registers only load on a pop, which keeps data_* stable for the whole REQ phase.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_wstrb <= commit_store_wstrb;
      r_size  <= map_size(commit_store_size);
      r_addr  <= map_addr(commit_store_addr);
      r_wdata <= commit_store_data;
    end
  end

`ifdef DRAIN_KSEG_MAP_EN
  logic r_uncached;

  always_ff @(posedge clk) begin
    if (w_pop) r_uncached <= (commit_store_addr[31:29] == 3'b101);
  end

  assign data_uncached = w_req & r_uncached;
`else
  assign data_uncached = 1'b0;
`endif

  assign commit_store_valid = w_pop;
  assign data_req           = w_req;
  assign data_wr            = w_req;
  assign data_size          = w_req ? r_size  : 2'd0;
  assign data_wstrb         = w_req ? r_wstrb : 4'd0;
  assign data_addr          = w_req ? r_addr  : 32'd0;
  assign data_wdata         = w_req ? r_wdata : 32'd0;
  assign pending_cnt        = r_pending;
  assign store_drained      = (r_pending == '0) && (r_state == S_IDLE);
  assign overflow_err       = r_overflow;

endmodule
